// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
// Each op is computed at launch, held as pending, and committed to HI/LO after a fixed latency.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_sel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]    MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LAT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   pend_reg, pend_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;

  // Products: sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned multiply the signed product.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc;
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {hi_reg, lo_reg};

  // Signed division runs on magnitudes; signs are reapplied afterwards (quotient toward zero, remainder follows dividend).
  logic             div_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, num, den, q_u, r_u, quot, rem;
  assign div_signed = (mdop == OP_DIV);
  assign a_neg      = div_signed && a[WIDTH-1];
  assign b_neg      = div_signed && b[WIDTH-1];
  assign a_mag      = ~a + ONE;
  assign b_mag      = ~b + ONE;
  assign num        = a_neg ? a_mag : a;
  assign den        = b_neg ? b_mag : b;
  assign q_u        = num / den;
  assign r_u        = num % den;
  assign quot       = (a_neg ^ b_neg) ? (~q_u + ONE) : q_u;
  assign rem        = a_neg ? (~r_u + ONE) : r_u;

  logic [2*WIDTH-1:0] op_result;
  always_comb begin
    op_result = '0;
    case (mdop)
      OP_MULT:  op_result = prod_s;
      OP_MULTU: op_result = prod_u;
      OP_MADD:  op_result = acc + prod_s;
      OP_MADDU: op_result = acc + prod_u;
      OP_DIV, OP_DIVU: begin
        if (b == '0) op_result = {a, {WIDTH{1'b1}}};
        else         op_result = {rem, quot};
      end
      default:  op_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pend_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start && !cancel) begin
          if (mdop == OP_MTHI) begin
            hi_next = a;
          end else if (mdop == OP_MTLO) begin
            lo_next = a;
          end else begin
            pend_next  = op_result;
            cnt_next   = (mdop[2:1] == 2'b01) ? DIV_LAT : MULT_LAT;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // Cancel takes priority over the final countdown edge.
        if (cancel) begin
          pend_next  = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CNT_ONE) begin
          {hi_next, lo_next} = pend_reg;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state_reg == BUSY);
  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign rdata = rd_sel ? hi_reg : lo_reg;

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core; it occupies the E stage alongside the ALU.
- Accepts one operation per start pulse and runs it for a fixed, per-class latency with `busy` high throughout, then commits to HI/LO.
- Generalises the core's single-cycle datapath: configurable width and latencies, signed/unsigned multiply-accumulate, and an in-flight cancel for flushed instructions.
- The hazard unit uses `busy`/`start` to stall mfhi/mflo/md instructions in D.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  launch/execute op on `mdop` this cycle
- mdop  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 mthi, 111 mtlo
- cancel  input  1  abort in-flight op (E-stage flush)
- a  input  WIDTH  rs operand
- b  input  WIDTH  rt operand
- rd_sel  input  1  0 selects LO, 1 selects HI on `rdata`
- busy  output  1  operation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- rdata  output  WIDTH  combinational mux of hi/lo by rd_sel (mfhi/mflo path)

## Operation
- States: IDLE, BUSY. Reset -> IDLE, hi=0, lo=0, busy=0, counter=0, pending result=0.
- IDLE, start, mdop in 000..101: compute result from `a`,`b` (and, for madd/maddu, from current `hi`/`lo`); latch it into the pending {hi,lo} register. Load counter = latency. Enter BUSY.
- IDLE, start, mdop 110/111: write `a` to hi/lo at the same edge. Stay IDLE; busy stays 0.
- BUSY: decrement counter each cycle. At the edge where counter goes 1->0, commit pending to hi/lo and return to IDLE.
- BUSY, start=1: ignored (no latch, no mthi/mtlo write). The hazard unit must prevent this; the bench checks it has no effect.
- cancel=1 in BUSY: return to IDLE at that edge; hi/lo unchanged; pending discarded.
- cancel=1 in IDLE with start=1: start suppressed; no write, including mthi/mtlo.
- Result rules (2·WIDTH arithmetic):
  - mult: signed a×b; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - multu: unsigned a×b.
  - madd/maddu: {hi,lo} + product mod 2^(2·WIDTH).
  - div/divu: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Division by zero: lo = all ones, hi = a.
  - Signed MIN/−1: lo = MIN, hi = 0.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- rdata reflects committed hi/lo only, never pending.

## Timing
- start sampled in cycle T, busy=0. busy=1 in cycles T+1..T+N, where N = MULT_CYCLES or DIV_CYCLES.
- hi/lo take the new value at the end of cycle T+N and are visible in T+N+1 with busy=0.
- A new start is accepted in T+N+1, giving back-to-back throughput of one op per N+1 cycles.
- mthi/mtlo: visible the cycle after start.
- Reset asserted mid-operation: busy, hi and lo go to 0 asynchronously; no commit occurs after deassertion.
- cancel and the final countdown edge in the same cycle: cancel wins, no commit.

## Test plan
- Reset, then mult a=0xFFFFFFFE(−2), b=3, MULT_CYCLES=5 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; rd_sel=1 gives rdata=0xFFFFFFFF.
- multu 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Follow with maddu a=1, b=0xFFFFFFFF -> hi=0xFFFFFFFF, lo=0x00000000.
- div a=−7 (0xFFFFFFF9), b=2, DIV_CYCLES=10 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> lo=0xFFFFFFFF, hi=7. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x12345678 while IDLE -> hi=0x12345678 next cycle, busy stays 0. During a BUSY div, start with mtlo a=5 -> lo unchanged, busy timing unaffected.
- div in flight, cancel in its 4th busy cycle -> busy=0 next cycle, hi/lo keep their prior values. Repeat with cancel on the final busy cycle -> still no commit.
- Reset pulsed asynchronously mid-mult, between clock edges -> busy, hi and lo read 0 before the next edge; no later commit.
